// File: rtl/tlp_action_arb.sv
// Action merger feeding tlp_send: buffers register actions from tlp_recv in a
// small FIFO and round-robins them against multi-beat DMA bursts. DMA bursts
// lock the channel until their last beat; overflow and over-length bursts are
// reported through sticky flags.

package tlp_xcvr_pkg;

  typedef struct packed {
    logic [1:0]  kind;
    logic [29:0] addr;
    logic [31:0] data;
  } Action;

endpackage

module tlp_action_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                              pcieClk_in,
  input  logic                              reset_in,
  input  tlp_xcvr_pkg::Action               recvData_in,
  input  logic                              recvValid_in,
  input  tlp_xcvr_pkg::Action               dmaData_in,
  input  logic                              dmaValid_in,
  input  logic                              dmaLast_in,
  output logic                              dmaReady_out,
  output tlp_xcvr_pkg::Action               actData_out,
  output logic                              actValid_out,
  input  logic                              actReady_in,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifoLevel_out,
  output logic                              overflow_out,
  output logic                              burstErr_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_OPEN,
    S_HOLD,
    S_DMA
  } state_t;

  typedef enum logic {
    SRC_RECV,
    SRC_DMA
  } src_t;

  tlp_xcvr_pkg::Action fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                fifo_full;
  logic                recv_pending;
  logic                push_ok;
  logic                recv_pop;
  logic                dma_xfer;
  logic                act_valid;

  state_t              state;
  state_t              state_next;
  src_t                grant;
  src_t                held_grant;
  src_t                held_grant_next;
  src_t                last_grant;
  src_t                last_grant_next;

  logic [7:0]          beat_count;
  logic                overflow;
  logic                burst_err;

  assign recv_pending = (level != '0);
  assign fifo_full    = (level == LVL_W'(FIFO_DEPTH));

  // Pick the granted source and drive the merged channel from it.
  always_comb begin
    grant = SRC_DMA;
    case (state)
      S_OPEN: begin
        if (recv_pending && (!dmaValid_in || last_grant == SRC_DMA)) begin
          grant = SRC_RECV;
        end
      end
      S_HOLD:  grant = held_grant;
      S_DMA:   grant = SRC_DMA;
      default: grant = SRC_DMA;
    endcase

    act_valid = 1'b0;
    if (!reset_in) begin
      act_valid = (grant == SRC_RECV) ? recv_pending : dmaValid_in;
    end

    recv_pop = act_valid && actReady_in && (grant == SRC_RECV);
    dma_xfer = act_valid && actReady_in && (grant == SRC_DMA);
    push_ok  = !reset_in && recvValid_in && (!fifo_full || recv_pop);

    actValid_out = act_valid;
    dmaReady_out = actReady_in && (grant == SRC_DMA) && !reset_in;
    actData_out  = 'x;
    if (act_valid) begin
      actData_out = (grant == SRC_RECV) ? fifo_mem[rd_ptr] : dmaData_in;
    end
  end

  // Decide the next arbitration state from this cycle's offer and handshake.
  always_comb begin
    state_next      = state;
    held_grant_next = held_grant;
    last_grant_next = last_grant;
    if (recv_pop) begin
      state_next      = S_OPEN;
      last_grant_next = SRC_RECV;
    end else if (dma_xfer) begin
      if (dmaLast_in) begin
        state_next      = S_OPEN;
        last_grant_next = SRC_DMA;
      end else begin
        state_next = S_DMA;
      end
    end else if (act_valid && state == S_OPEN) begin
      state_next      = S_HOLD;
      held_grant_next = grant;
    end
  end

  // Arbitration state register; after reset the recv side wins the first tie.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      state      <= S_OPEN;
      held_grant <= SRC_DMA;
      last_grant <= SRC_DMA;
    end else begin
      state      <= state_next;
      held_grant <= held_grant_next;
      last_grant <= last_grant_next;
    end
  end

  // FIFO storage; an entry is only written when there is room for it.
  always_ff @(posedge pcieClk_in) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= recvData_in;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (recv_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !recv_pop) begin
        level <= level + LVL_W'(1);
      end else if (!push_ok && recv_pop) begin
        level <= level - LVL_W'(1);
      end
      if (recvValid_in && fifo_full && !recv_pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Count DMA beats within a burst and flag bursts that run past the limit.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      beat_count <= '0;
      burst_err  <= 1'b0;
    end else if (dma_xfer) begin
      if (!dmaLast_in && beat_count == BURST_LIMIT) begin
        burst_err <= 1'b1;
      end
      if (dmaLast_in) begin
        beat_count <= '0;
      end else if (beat_count != 8'hFF) begin
        beat_count <= beat_count + 8'd1;
      end
    end
  end

  assign fifoLevel_out = level;
  assign overflow_out  = overflow;
  assign burstErr_out  = burst_err;

endmodule

// File: tb/tb_tlp_action_arb.sv
// Bench for tlp_action_arb: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based reference model.

module tb_tlp_action_arb;
  import tlp_xcvr_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int MAX_BURST  = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  localparam int SRC_NONE = 0;
  localparam int SRC_RECV = 1;
  localparam int SRC_DMA  = 2;

  typedef struct {
    Action data;
    bit    last;
  } Beat;

  logic             clk = 1'b0;
  logic             resetIn;
  Action            recvData;
  logic             recvValid;
  Action            dmaData;
  logic             dmaValid;
  logic             dmaLast;
  logic             dmaReady;
  Action            actData;
  logic             actValid;
  logic             actReady;
  logic [LVL_W-1:0] fifoLevel;
  logic             overflow;
  logic             burstErr;

  always #4 clk = ~clk;

  tlp_action_arb #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .pcieClk_in    (clk),
    .reset_in      (resetIn),
    .recvData_in   (recvData),
    .recvValid_in  (recvValid),
    .dmaData_in    (dmaData),
    .dmaValid_in   (dmaValid),
    .dmaLast_in    (dmaLast),
    .dmaReady_out  (dmaReady),
    .actData_out   (actData),
    .actValid_out  (actValid),
    .actReady_in   (actReady),
    .fifoLevel_out (fifoLevel),
    .overflow_out  (overflow),
    .burstErr_out  (burstErr)
  );

  int totalChecks = 0;
  int badChecks   = 0;

  // Reference model state, in terms of the behaviour rather than the circuit.
  Action modelFifo [$];
  bit    modelOvf;
  bit    modelErr;
  bit    modelLocked;
  bit    modelLastDma;
  int    modelHeld;
  int    modelBeats;

  // DMA engine behaviour: queued beats, valid held once offered.
  Beat   dmaQ [$];
  bit    dmaOffered;

  // Every accepted output action, in order.
  Action outLog [$];

  logic             obsValid;
  Action            obsData;
  logic             obsReady;
  logic [LVL_W-1:0] obsLevel;
  logic             obsOvf;
  logic             obsBerr;

  // Count a comparison and report it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
    end
  endtask

  function automatic Action mk(input int tag);
    return Action'({32'(tag) ^ 32'hC0DE_0000, 32'(tag)});
  endfunction

  task automatic modelReset();
    modelFifo.delete();
    modelOvf     = 1'b0;
    modelErr     = 1'b0;
    modelLocked  = 1'b0;
    modelLastDma = 1'b1;
    modelHeld    = SRC_NONE;
    modelBeats   = 0;
    dmaQ.delete();
    dmaOffered   = 1'b0;
  endtask

  task automatic pushBurst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      dmaQ.push_back('{data: mk(base + i), last: (i == n - 1)});
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model across the following rising edge.
  task automatic applyStimulus(input bit rst, input bit rv, input Action rd, input bit rdy, input bit gate);
    bit    dv;
    Action dd;
    bit    dl;
    int    src;
    bit    recvPend;
    bit    expValid;
    Action expData;
    bit    xfer;
    bit    popped;
    bit    wasFull;

    dv = (dmaQ.size() > 0) && (gate || dmaOffered);
    dd = '0;
    dl = 1'b0;
    if (dv) begin
      dd = dmaQ[0].data;
      dl = dmaQ[0].last;
    end
    resetIn   = rst;
    recvValid = rv;
    recvData  = rd;
    dmaValid  = dv;
    dmaData   = dd;
    dmaLast   = dl;
    actReady  = rdy;
    #1;
    obsValid = actValid;
    obsData  = actData;
    obsReady = dmaReady;
    obsLevel = fifoLevel;
    obsOvf   = overflow;
    obsBerr  = burstErr;

    if (rst) begin
      checkOutput("rst_valid", 64'(obsValid), 64'd0);
      checkOutput("rst_ready", 64'(obsReady), 64'd0);
      modelReset();
    end else begin
      recvPend = (modelFifo.size() > 0);
      if (modelLocked) src = SRC_DMA;
      else if (modelHeld != SRC_NONE) src = modelHeld;
      else if (recvPend && dv) src = modelLastDma ? SRC_RECV : SRC_DMA;
      else if (recvPend) src = SRC_RECV;
      else src = SRC_DMA;

      expValid = (src == SRC_RECV) ? recvPend : dv;
      expData  = (src == SRC_RECV) ? (recvPend ? modelFifo[0] : Action'('0)) : dd;

      checkOutput("act_valid", 64'(obsValid), 64'(expValid));
      if (expValid) checkOutput("act_data", obsData, expData);
      checkOutput("dma_ready", 64'(obsReady), 64'(rdy && src == SRC_DMA));
      checkOutput("fifo_level", 64'(obsLevel), 64'(modelFifo.size()));
      checkOutput("overflow", 64'(obsOvf), 64'(modelOvf));
      checkOutput("burst_err", 64'(obsBerr), 64'(modelErr));

      if (obsValid && rdy) outLog.push_back(obsData);

      xfer    = expValid && rdy;
      wasFull = (modelFifo.size() == FIFO_DEPTH);
      popped  = 1'b0;
      if (xfer && src == SRC_RECV) begin
        void'(modelFifo.pop_front());
        popped       = 1'b1;
        modelLastDma = 1'b0;
        modelHeld    = SRC_NONE;
      end else if (xfer) begin
        if (!dl && modelBeats == MAX_BURST - 1) modelErr = 1'b1;
        if (dl) begin
          modelBeats   = 0;
          modelLocked  = 1'b0;
          modelLastDma = 1'b1;
        end else begin
          modelBeats  = (modelBeats < 255) ? modelBeats + 1 : 255;
          modelLocked = 1'b1;
        end
        modelHeld = SRC_NONE;
        void'(dmaQ.pop_front());
      end else if (expValid && !modelLocked) begin
        modelHeld = src;
      end
      dmaOffered = dv && !(xfer && src == SRC_DMA);

      if (rv) begin
        if (wasFull && !popped) modelOvf = 1'b1;
        else modelFifo.push_back(rd);
      end
    end
    @(negedge clk);
  endtask

  task automatic checkLog(input string tag, input Action exp [$]);
    checkOutput({tag, "_count"}, 64'(outLog.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      checkOutput($sformatf("%s_%0d", tag, i), (i < outLog.size()) ? outLog[i] : Action'('0), exp[i]);
    end
  endtask

  initial begin
    Action expList [$];

    resetIn   = 1'b1;
    recvValid = 1'b0;
    recvData  = '0;
    dmaValid  = 1'b0;
    dmaData   = '0;
    dmaLast   = 1'b0;
    actReady  = 1'b0;
    modelReset();
    @(negedge clk);

    // Reset, then single recv action with 1-cycle latency.
    applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(0, 1, mk(1), 1, 0);
    checkOutput("t1_idle_valid", 64'(obsValid), 64'd0);
    checkOutput("t1_idle_level", 64'(obsLevel), 64'd0);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t1_valid", 64'(obsValid), 64'd1);
    checkOutput("t1_data", obsData, mk(1));
    checkOutput("t1_level1", 64'(obsLevel), 64'd1);
    applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t1_level0", 64'(obsLevel), 64'd0);

    // Round robin with 2-beat DMA bursts against queued recv actions.
    outLog.delete();
    applyStimulus(0, 1, mk(100), 0, 1);
    applyStimulus(0, 1, mk(101), 0, 1);
    applyStimulus(0, 1, mk(102), 0, 1);
    pushBurst(2, 200);
    pushBurst(2, 210);
    applyStimulus(0, 0, '0, 0, 1);
    repeat (9) applyStimulus(0, 0, '0, 1, 1);
    expList = '{mk(100), mk(200), mk(201), mk(101), mk(210), mk(211), mk(102)};
    checkLog("t2_order", expList);

    // Overflow: five pushes into a four-entry FIFO with the sink stalled.
    applyStimulus(1, 0, '0, 0, 0);
    outLog.delete();
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, mk(300 + i), 0, 0);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("t3_level", 64'(obsLevel), 64'd4);
    checkOutput("t3_ovf", 64'(obsOvf), 64'd1);
    repeat (6) applyStimulus(0, 0, '0, 1, 0);
    checkOutput("t3_ovf_sticky", 64'(obsOvf), 64'd1);
    expList = '{mk(300), mk(301), mk(302), mk(303)};
    checkLog("t3_order", expList);

    // Full FIFO with a simultaneous push and pop.
    applyStimulus(1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, mk(400 + i), 0, 0);
    applyStimulus(0, 1, mk(404), 1, 0);
    applyStimulus(0, 0, '0, 0, 0);
    checkOutput("t4_level", 64'(obsLevel), 64'd4);
    checkOutput("t4_ovf", 64'(obsOvf), 64'd0);

    // DMA beat held under backpressure while a recv action arrives.
    applyStimulus(1, 0, '0, 0, 0);
    outLog.delete();
    pushBurst(2, 500);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, (i == 1), mk(510), 0, 1);
      checkOutput("t5_hold_data", obsData, mk(500));
      checkOutput("t5_hold_ready", 64'(obsReady), 64'd0);
    end
    repeat (4) applyStimulus(0, 0, '0, 1, 1);
    expList = '{mk(500), mk(501), mk(510)};
    checkLog("t5_order", expList);

    // Six-beat burst past a limit of four, then reset mid-burst.
    applyStimulus(1, 0, '0, 0, 0);
    outLog.delete();
    pushBurst(6, 600);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 0, '0, 1, 1);
      if (k == 4) checkOutput("t6_err_before", 64'(obsBerr), 64'd0);
      if (k == 5) checkOutput("t6_err_after", 64'(obsBerr), 64'd1);
    end
    applyStimulus(0, 0, '0, 1, 1);
    expList = '{mk(600), mk(601), mk(602), mk(603), mk(604), mk(605)};
    checkLog("t6_order", expList);
    pushBurst(3, 700);
    applyStimulus(0, 1, mk(710), 1, 1);
    applyStimulus(1, 0, '0, 1, 1);
    checkOutput("t6_rst_valid", 64'(obsValid), 64'd0);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("t6_rst_err", 64'(obsBerr), 64'd0);
    checkOutput("t6_rst_level", 64'(obsLevel), 64'd0);
    checkOutput("t6_rst_idle", 64'(obsValid), 64'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (dmaQ.size() == 0 && $urandom_range(0, 3) == 0) pushBurst($urandom_range(1, 6), 1000 + c * 8);
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 4, Action'({$urandom, $urandom}),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/tlp_action_arb.md
Name: tlp_action_arb

Overview:
- Merges action streams into the single action channel consumed by tlp_send.
- Stream 1: register read/write actions from tlp_recv. These are valid-only with no backpressure, so the block buffers them in a small FIFO.
- Stream 2: multi-beat actions from the FPGA->CPU DMA engine, with valid/ready and a last flag.
- Arbitration: fair round-robin between the two streams, locked for the full length of a DMA burst. Overflow and burst-length violations are flagged.

Parameters:
- FIFO_DEPTH, 4, entries in the recv-action FIFO; power of 2, minimum 2.
- MAX_BURST, 16, maximum legal DMA burst length in beats; range 1..255.

Ports:
- pcieClk_in  in  1  125MHz PCIe core clock
- reset_in  in  1  synchronous active-high reset
- recvData_in  in  tlp_xcvr_pkg::Action  action from tlp_recv
- recvValid_in  in  1  push strobe from tlp_recv; no ready
- dmaData_in  in  tlp_xcvr_pkg::Action  DMA engine action beat
- dmaValid_in  in  1  DMA beat valid
- dmaLast_in  in  1  final beat of DMA burst; qualified by dmaValid_in
- dmaReady_out  out  1  DMA beat accepted when high with dmaValid_in
- actData_out  out  tlp_xcvr_pkg::Action  merged action to tlp_send
- actValid_out  out  1  merged action valid
- actReady_in  in  1  tlp_send ready
- fifoLevel_out  out  $clog2(FIFO_DEPTH+1)  current recv FIFO occupancy
- overflow_out  out  1  sticky: recv action dropped
- burstErr_out  out  1  sticky: DMA burst exceeded MAX_BURST beats

Behaviour:
- Reset (reset_in high at posedge): FIFO emptied, state=S_OPEN, lastGrant=DMA (recv wins first tie), beatCount=0, sticky flags cleared.
- While reset_in is high: actValid_out=0, dmaReady_out=0, recv pushes ignored.
- Reset mid-burst abandons the burst; the DMA engine must restart it.
- Recv FIFO, push side:
  - Push on recvValid_in.
  - Data written at edge N is visible at the FIFO head from cycle N+1; minimum recv->act latency is 1 cycle.
  - Push while full with no simultaneous pop: entry dropped, overflow_out set until reset.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no drop.
- Recv FIFO, pop side: pop occurs when the recv source transfers (actValid_out && actReady_in && grant==RECV). Pointers wrap modulo FIFO_DEPTH.
- DMA path: combinational pass-through, zero latency. dmaReady_out = actReady_in && grant==DMA && !reset_in.
- Output mux:
  - actData_out/actValid_out come from the granted source.
  - actValid_out = granted source valid.
  - actData_out = 'X when actValid_out=0.
- FSM states:
  - S_OPEN: no burst in progress.
    - Only one source pending: grant to it.
    - Both pending: grant to the source not equal to lastGrant.
  - S_HOLD: an offered beat was not accepted. Grant is frozen until the transfer completes, so data is stable under backpressure.
  - S_DMA: mid-burst lock. Only DMA is granted; the FIFO still accepts pushes. Exit to S_OPEN on the transfer with dmaLast_in=1.
- Transitions:
  - S_OPEN offer, no ready -> S_HOLD.
  - S_OPEN or S_HOLD DMA transfer with dmaLast_in=0 -> S_DMA.
  - Any recv transfer, or DMA transfer with last -> S_OPEN.
- lastGrant is updated on every completed single-beat recv transfer and every completed DMA burst (last beat).
- beatCount:
  - 8 bits; increments on each DMA transfer; cleared on the last beat.
  - If a transfer occurs with beatCount==MAX_BURST-1 and dmaLast_in=0, burstErr_out is set (sticky). The lock is kept until last arrives; bursts are never truncated.
  - beatCount saturates at 255.
- Simultaneous events: the recv push in the same cycle as a grant decision is not visible to that decision; it competes from the next cycle.
- Empty FIFO with DMA idle: actValid_out=0.

Test Plan:
- Reset, then recvValid_in for 1 cycle with action A, actReady_in=1 -> actValid_out=1 with A exactly 1 cycle later; fifoLevel_out goes 1->0.
- Both pending continuously: 3 recv actions R0..R2 queued, DMA 2-beat bursts D0a/D0b, D1a/D1b, actReady_in=1 -> output order R0,D0a,D0b,R1,D1a,D1b,R2.
- FIFO_DEPTH=4, actReady_in=0, 5 consecutive recv pushes -> fifoLevel_out=4; 5th dropped; overflow_out=1 stays high; release ready -> exactly the first 4 actions emerge in order.
- Full FIFO, push and pop in the same cycle -> level stays 4, overflow_out remains 0.
- DMA beat offered, actReady_in=0 for 3 cycles, recv push arrives meanwhile -> actData_out stays the DMA beat and dmaReady_out=0 throughout; after ready, the DMA burst completes before the recv action is output.
- MAX_BURST=4, 6-beat DMA burst -> burstErr_out rises on the 4th-beat transfer; all 6 beats pass uninterrupted; then reset_in pulse mid-new-burst -> actValid_out=0 next cycle, burstErr_out=0, fifoLevel_out=0.
